cobro_pago: RTL

Payment-collection stage directly upstream of the coffee machine controller; it produces the controller's PAGO_RECIBIDO.
- Latches the order price `precio` when an order is requested and accumulates inserted coins.
- When credit covers the price, emits a one-cycle PAGO_RECIBIDO pulse together with the change owed.
- Refunds the full credit on user cancel or on an inactivity timeout.

---
 rtl/cafe_pkg.sv | 37 +++
 rtl/temporizador_inactividad.sv | 41 ++++
 rtl/cobro_pago.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cafe_pkg.sv
// -----------------------------------------------------------------------------
// cafe_pkg
// Shared definitions for the coffee-machine payment path:
//   - PRECIO_W / CREDITO_W : widths of the order price and the accumulated credit
//   - MONEDA_*             : 2-bit coin codes
//   - estado_t             : collection FSM states
//   - valor_moneda()       : coin code -> value in coin units (CREDITO_W bits)
// -----------------------------------------------------------------------------
package cafe_pkg;

    localparam int PRECIO_W  = 4;
    localparam int CREDITO_W = 5;

    localparam logic [1:0] MONEDA_1  = 2'd0;
    localparam logic [1:0] MONEDA_2  = 2'd1;
    localparam logic [1:0] MONEDA_5  = 2'd2;
    localparam logic [1:0] MONEDA_10 = 2'd3;

    typedef enum logic [1:0] {
        INACTIVO    = 2'd0,
        COBRANDO    = 2'd1,
        PAGADO      = 2'd2,
        DEVOLVIENDO = 2'd3
    } estado_t;

    function automatic logic [CREDITO_W-1:0] valor_moneda(input logic [1:0] codigo);
        logic [CREDITO_W-1:0] valor;
        case (codigo)
            MONEDA_1: valor = CREDITO_W'(1);
            MONEDA_2: valor = CREDITO_W'(2);
            MONEDA_5: valor = CREDITO_W'(5);
            default:  valor = CREDITO_W'(10);
        endcase
        return valor;
    endfunction

endpackage

// File: rtl/temporizador_inactividad.sv
// -----------------------------------------------------------------------------
// temporizador_inactividad
// Counts consecutive coin-less cycles while collecting.
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   i_limpiar   clear the count (coin accepted, or not collecting)
//   i_contar    count this cycle as idle
//   o_expirado  high in the idle cycle that brings the count to TIMEOUT_CICLOS,
//               so the owner can leave the collecting state on that same edge
// -----------------------------------------------------------------------------
module temporizador_inactividad #(
    parameter int TIMEOUT_CICLOS = 255,
    parameter int ANCHO_TMR      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_limpiar,
    input  logic i_contar,
    output logic o_expirado
);

    localparam logic [ANCHO_TMR-1:0] LIMITE = ANCHO_TMR'(TIMEOUT_CICLOS - 1);

    logic [ANCHO_TMR-1:0] r_cuenta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cuenta <= '0;
        end else if (i_limpiar) begin
            r_cuenta <= '0;
        end else if (i_contar) begin
            r_cuenta <= r_cuenta + 1'b1;
        end
    end

    // r_cuenta holds the idle cycles already elapsed; this idle cycle is the
    // TIMEOUT_CICLOS-th one when the count sits one below the limit.
    assign o_expirado = i_contar && !i_limpiar && (r_cuenta == LIMITE);

endmodule

// File: rtl/cobro_pago.sv
// -----------------------------------------------------------------------------
// cobro_pago
// Payment collection ahead of the coffee controller. Latches the order price,
// accumulates coins, pulses PAGO_RECIBIDO with the change once the price is
// covered, and refunds the credit on cancel or inactivity timeout.
// Ports:
//   clk, reset        clock / asynchronous active-low reset
//   precio            order price (coin units), sampled with pedido_valido
//   pedido_valido     one-cycle order request
//   moneda_valida     one-cycle coin strobe, moneda_valor = coin code
//   cancelar          user cancel
//   PAGO_RECIBIDO     one-cycle pulse, payment complete
//   cambio            change/refund, non-zero only with a pulse
//   devolucion        one-cycle refund pulse
//   credito           accumulated credit
//   ocupado           not idle
//   moneda_rechazada  one-cycle pulse after a coin arrives outside COBRANDO
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module cobro_pago
    import cafe_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 255,
    parameter int ANCHO_TMR      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PRECIO_W-1:0]  precio,
    input  logic                 pedido_valido,
    input  logic                 moneda_valida,
    input  logic [1:0]           moneda_valor,
    input  logic                 cancelar,
    output logic                 PAGO_RECIBIDO,
    output logic [CREDITO_W-1:0] cambio,
    output logic                 devolucion,
    output logic [CREDITO_W-1:0] credito,
    output logic                 ocupado,
    output logic                 moneda_rechazada
);

    estado_t                r_estado, w_estado_next;
    logic [PRECIO_W-1:0]    r_precio, w_precio_next;
    logic [CREDITO_W-1:0]   r_credito, w_credito_next;
    logic [CREDITO_W-1:0]   r_cambio, w_cambio_next;
    logic                   r_pago, w_pago_next;
    logic                   r_devol, w_devol_next;
    logic                   r_rechazo, w_rechazo_next;
    logic                   r_ocupado;
    logic [CREDITO_W-1:0]   w_suma;
    logic                   w_cobrando;
    logic                   w_expirado;

    assign w_cobrando = (r_estado == COBRANDO);

    // Idle timer: held at zero outside COBRANDO so every collection starts fresh.
    temporizador_inactividad #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .ANCHO_TMR      (ANCHO_TMR)
    ) u_temporizador (
        .clk        (clk),
        .reset      (reset),
        .i_limpiar  (!w_cobrando || moneda_valida),
        .i_contar   (w_cobrando && !moneda_valida),
        .o_expirado (w_expirado)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado  <= INACTIVO;
            r_precio  <= '0;
            r_credito <= '0;
            r_cambio  <= '0;
            r_pago    <= 1'b0;
            r_devol   <= 1'b0;
            r_rechazo <= 1'b0;
            r_ocupado <= 1'b0;
        end else begin
            r_estado  <= w_estado_next;
            r_precio  <= w_precio_next;
            r_credito <= w_credito_next;
            r_cambio  <= w_cambio_next;
            r_pago    <= w_pago_next;
            r_devol   <= w_devol_next;
            r_rechazo <= w_rechazo_next;
            r_ocupado <= (w_estado_next != INACTIVO);
        end
    end

    always_comb begin
        w_estado_next  = r_estado;
        w_precio_next  = r_precio;
        w_credito_next = r_credito;
        w_cambio_next  = '0;
        w_pago_next    = 1'b0;
        w_devol_next   = 1'b0;
        // Coins are only accepted while collecting; a coin arriving together
        // with the request is still seen in INACTIVO and therefore rejected.
        w_rechazo_next = moneda_valida && !w_cobrando;
        // Credit stays below the price (max 14) so credit + 10 fits in 5 bits.
        w_suma         = moneda_valida ? (r_credito + valor_moneda(moneda_valor)) : r_credito;

        case (r_estado)
            INACTIVO: begin
                if (pedido_valido) begin
                    w_precio_next  = precio;
                    w_credito_next = '0;
                    if (precio == '0) begin
                        w_estado_next = PAGADO;
                        w_pago_next   = 1'b1;
                    end else begin
                        w_estado_next = COBRANDO;
                    end
                end
            end
            COBRANDO: begin
                // Cancel beats completion and refunds a coin inserted alongside it.
                if (cancelar) begin
                    w_estado_next  = DEVOLVIENDO;
                    w_devol_next   = 1'b1;
                    w_cambio_next  = w_suma;
                    w_credito_next = '0;
                end else if (w_suma >= {1'b0, r_precio}) begin
                    w_estado_next  = PAGADO;
                    w_pago_next    = 1'b1;
                    w_cambio_next  = w_suma - {1'b0, r_precio};
                    w_credito_next = '0;
                end else if (w_expirado) begin
                    // Expiry only happens on coin-less cycles, so suma == credit.
                    w_estado_next  = DEVOLVIENDO;
                    w_devol_next   = 1'b1;
                    w_cambio_next  = r_credito;
                    w_credito_next = '0;
                end else begin
                    w_credito_next = w_suma;
                end
            end
            PAGADO, DEVOLVIENDO: begin
                w_estado_next  = INACTIVO;
                w_credito_next = '0;
            end
            default: begin
                w_estado_next  = INACTIVO;
                w_credito_next = '0;
            end
        endcase
    end

    assign PAGO_RECIBIDO    = r_pago;
    assign devolucion       = r_devol;
    assign cambio           = r_cambio;
    assign credito          = r_credito;
    assign ocupado          = r_ocupado;
    assign moneda_rechazada = r_rechazo;

endmodule
